// File: rtl/decoder_1bit_reg_if.sv
// Interface bundle for the registered 1-to-2 line decoder.
//   en    : load enable; a high level captures `in` on the next rising clk
//   in    : per-lane select bits, LANES wide
//   out1  : per-lane decoded line 0 (high when the captured bit was 0)
//   out2  : per-lane decoded line 1 (high when the captured bit was 1)
//   valid : high for the cycle after a capture
// The master modport is the upstream driver of en/in. The slave modport is
// the decoder itself.
interface decoder_1bit_reg_if #(
    parameter int unsigned LANES = 1
);
    logic             en;
    logic [LANES-1:0] in;
    logic [LANES-1:0] out1;
    logic [LANES-1:0] out2;
    logic             valid;

    modport master (
        output en,
        output in,
        input  out1,
        input  out2,
        input  valid
    );

    modport slave (
        input  en,
        input  in,
        output out1,
        output out2,
        output valid
    );
endinterface

// File: rtl/decoder_1bit_reg.sv
// Registered 1-to-2 line decoder, replicated across LANES independent lanes.
// When en is high, the decoder captures each select bit on the rising clk edge
// and turns it into a one-hot pair (out1 for select 0, out2 for select 1).
// Every output comes straight from a flop, so no combinational path runs from
// en or in to any output.
//   clk   : system clock, rising-edge active
//   rst_n : asynchronous active-low reset; clears out1, out2 and valid
//   bus   : decoder_1bit_reg_if slave modport (en, in, out1, out2, valid)
// LANES must match the LANES parameter of the connected interface.
module decoder_1bit_reg #(
    parameter int unsigned LANES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decoder_1bit_reg_if.slave     bus
);

    logic [LANES-1:0] out1_q;
    logic [LANES-1:0] out2_q;
    logic             valid_q;

    // Reset gives the only state with both lines low on a lane. Any capture
    // afterwards leaves each lane with exactly one of out1 and out2 high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_q  <= '0;
            out2_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.en;
            if (bus.en) begin
                out1_q <= ~bus.in;
                out2_q <= bus.in;
            end
        end
    end

    assign bus.out1  = out1_q;
    assign bus.out2  = out2_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_decoder_1bit_reg.sv
// Self-checking bench for decoder_1bit_reg. A 4-lane instance receives the
// stimulus directly. A 1-lane instance follows lane 0 of the same stimulus.
module tb_decoder_1bit_reg;

    logic clk;
    logic rst_n;

    decoder_1bit_reg_if #(.LANES(4)) bus4 ();
    decoder_1bit_reg_if #(.LANES(1)) bus1 ();

    assign bus1.en = bus4.en;
    assign bus1.in = bus4.in[0];

    decoder_1bit_reg #(.LANES(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    decoder_1bit_reg #(.LANES(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Checks both instances against one expected 4-lane state.
    // The 1-lane instance must match lane 0 of that state.
    task automatic check_all(input string tag, input logic [3:0] e1, input logic [3:0] e2, input logic ev);
        check({tag, " out1"},     {28'd0, bus4.out1}, {28'd0, e1});
        check({tag, " out2"},     {28'd0, bus4.out2}, {28'd0, e2});
        check({tag, " valid"},    {31'd0, bus4.valid}, {31'd0, ev});
        check({tag, " l1 out1"},  {31'd0, bus1.out1}, {31'd0, e1[0]});
        check({tag, " l1 out2"},  {31'd0, bus1.out2}, {31'd0, e2[0]});
        check({tag, " l1 valid"}, {31'd0, bus1.valid}, {31'd0, ev});
    endtask

    typedef struct {
        logic       en;
        logic [3:0] in;
        logic [3:0] out1;
        logic [3:0] out2;
        logic       valid;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        logic [3:0] m1, m2, prev1, prev2;
        logic       mv, prevv;
        logic       ren;
        logic [3:0] rin;

        vecs[0] = '{1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b1};
        vecs[1] = '{1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b1};
        vecs[2] = '{1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0};
        vecs[3] = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 1'b0};
        vecs[4] = '{1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0};
        vecs[5] = '{1'b1, 4'b1010, 4'b0101, 4'b1010, 1'b1};
        vecs[6] = '{1'b1, 4'b0011, 4'b1100, 4'b0011, 1'b1};
        vecs[7] = '{1'b0, 4'b0101, 4'b1100, 4'b0011, 1'b0};
        vecs[8] = '{1'b1, 4'b0110, 4'b1001, 4'b0110, 1'b1};

        // Hold reset while en=1 and in toggles.
        // The outputs must stay cleared, including before any clock edge.
        rst_n   = 1'b0;
        bus4.en = 1'b1;
        bus4.in = 4'b1010;
        #2;
        check_all("reset pre-clock", 4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus4.in = ~bus4.in;
            @(posedge clk);
            #1;
            check_all("reset held", 4'b0000, 4'b0000, 1'b0);
        end

        // Release reset with en=0. The first edge only clears valid.
        @(negedge clk);
        rst_n   = 1'b1;
        bus4.en = 1'b0;
        bus4.in = 4'b0000;
        @(posedge clk);
        #1;
        check_all("post-release idle", 4'b0000, 4'b0000, 1'b0);

        // Table-driven vectors. Right after the inputs change, the outputs must
        // still show the previous state, so no combinational path exists.
        prev1 = 4'b0000;
        prev2 = 4'b0000;
        prevv = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            bus4.en = vecs[i].en;
            bus4.in = vecs[i].in;
            #1;
            check_all($sformatf("vec%0d pre-edge", i), prev1, prev2, prevv);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].out1, vecs[i].out2, vecs[i].valid);
            prev1 = vecs[i].out1;
            prev2 = vecs[i].out2;
            prevv = vecs[i].valid;
        end

        // Capture all ones, then assert reset between edges.
        @(negedge clk);
        bus4.en = 1'b1;
        bus4.in = 4'b1111;
        @(posedge clk);
        #1;
        check_all("pre-async", 4'b0000, 4'b1111, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async reset", 4'b0000, 4'b0000, 1'b0);
        // An edge during reset with en=1 must not capture.
        @(posedge clk);
        #1;
        check_all("reset edge lost", 4'b0000, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("after async reset", 4'b0000, 4'b1111, 1'b1);

        // Random en/in against a one-cycle-delayed model.
        // The XOR invariant also holds here, because a capture has already happened.
        m1 = 4'b0000;
        m2 = 4'b1111;
        mv = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            ren = 1'($urandom_range(0, 1));
            rin = 4'($urandom);
            bus4.en = ren;
            bus4.in = rin;
            @(posedge clk);
            #1;
            mv = ren;
            if (ren) begin
                m1 = ~rin;
                m2 = rin;
            end
            check_all("random", m1, m2, mv);
            check("random xor", {28'd0, bus4.out1 ^ bus4.out2}, 32'hF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
